dm_arbiter: RTL
===============

# dm_arbiter

Two-port arbiter and sequencer in front of the single-port data memory. It accepts load/store transactions from two requesters: port 0 is the CPU MEM stage, port 1 is the debug/DMA port. It grants them round-robin, drives the memory's op/address/write-data/write-enable for exactly one cycle, and returns registered read data with an ack pulse. Alignment and range faults are checked here, so the memory only ever sees legal accesses.

## Interface
Parameters:
- ADDR_LIMIT, 32'h0000_1000: byte addresses at or above this return an error.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting low forces reset state immediately
- m0_req, m1_req  in  1  transaction request; held high until ack
- m0_we, m1_we  in  1  1 = store, 0 = load
- m0_op, m1_op  in  3  000 word, 001 lb, 010 lh, 011 sb, 100 sh, 101 lboez
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  store data (sb/sh use low bits)
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  valid with ack: access rejected
- m0_rdata, m1_rdata  out  32  valid with ack for loads; 0 on error and on stores
- dm_op  out  3  op to memory (latched op)
- dm_addr  out  32  address to memory
- dm_wdata  out  32  write data to memory
- dm_we  out  1  memory write enable
- dm_rdata  in  32  combinational read data from memory
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, with any req high at an edge:
  - Pick the winner.
  - Latch the winner's we/op/addr/wdata plus its owner id.
  - Compute the error flag.
  - Go to ACCESS.
- ACCESS:
  - dm_op/dm_addr/dm_wdata driven from the latched command.
  - dm_we = latched_we & ~err.
  - At the edge, store commits in memory, rdata register captures dm_rdata (load, no error) or 0, then go to DONE.
- DONE:
  - ack of the owner port = 1; the other ack = 0.
  - err and rdata held from the registers.
  - Next edge goes to IDLE unconditionally.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the port not granted last wins.
  - Last-grant pointer resets to port 1, so port 0 wins the first tie.
  - Pointer updates only on grant.
- Error when any of:
  - addr >= ADDR_LIMIT
  - op word with addr[1:0] != 0
  - op lh/sh with addr[0] != 0
  - op 110 or 111
  - we=1 with op lb/lh/lboez
  - we=0 with op sb/sh
- An errored transaction takes the same path and latency; memory sees dm_we=0.
- Latched command is immune to requester changes after the grant edge. If req drops mid-transaction, the transaction still completes and ack still pulses.
- dm outputs outside ACCESS: dm_we=0, op/addr/wdata hold the last latched values.
- Data widths: no width conversion here; sub-word alignment and extension are done by the memory according to dm_op.

## Timing
- Reset (low) values:
  - state IDLE
  - all acks, errs, rdata, dm_we, busy = 0
  - dm_op/dm_addr/dm_wdata = 0
  - last-grant = port 1
- Latency: req sampled high at edge E0; ACCESS during E0–E1; ack high during E1–E2; next grant sampled at E3 at the earliest.
- Throughput: one transaction per 3 cycles.
- Requester must drop req in the cycle following ack, i.e. sampled low at E3. A req still high at E3 is a new transaction.
- Reset asserted during ACCESS: dm_we falls immediately (asynchronously) and the store does not commit. No ack is ever issued for the aborted transaction.
- Reset deasserted: first grant is possible at the first edge with reset high.
- busy is high exactly in ACCESS and DONE.

## Test plan
- Port 0 word store addr 0x10 data 0xDEADBEEF, then word load of 0x10 -> dm_we high exactly one cycle; second ack returns rdata 0xDEADBEEF, err 0; ack 2 cycles after grant edge.
- m0_req and m1_req held high together for 4 transactions -> grants alternate 0,1,0,1. Neither ack ever fires in the same cycle as the other. A new grant never occurs within 3 cycles of the previous one.
- Port 1 sb 0x000000AB at addr 0x21, then lb at 0x21 -> rdata 0xFFFFFFAB.
- Port 0 lh at addr 0x13 -> m0_ack with m0_err=1, rdata 0, dm_we never high. Port 1 word store at 0x1000 -> err=1, no memory write.
- Word store of 0x12345678 to 0x40 with reset pulled low mid-ACCESS, then reset released and word load of 0x40 -> no ack for the store, busy 0 during reset, load returns prior contents (0).
- m0_req dropped right after the grant edge -> m0_ack still pulses once. The dropped request is not re-granted.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Port 0 is the CPU MEM stage, port 1 is the debug/DMA port. Each grant runs
// IDLE -> ACCESS -> DONE: the memory is driven for exactly one cycle in ACCESS,
// and the owner sees a one-cycle ack in DONE with registered err/rdata.
// Illegal accesses (range, alignment, bad op, load/store mismatch) are
// flagged here and reach the memory with the write enable suppressed.
module dm_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_op,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_op,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic [2:0]  dm_op,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata,

  output logic        busy
);

  localparam logic [2:0] OpWord  = 3'b000;
  localparam logic [2:0] OpLb    = 3'b001;
  localparam logic [2:0] OpLh    = 3'b010;
  localparam logic [2:0] OpSb    = 3'b011;
  localparam logic [2:0] OpSh    = 3'b100;
  localparam logic [2:0] OpLboez = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e      state_q, state_d;

  // Latched command of the current owner
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // Port that won the most recent grant; resets to 1 so port 0 wins the first tie
  logic        last_q, last_d;

  logic        any_req;
  logic        grant_port;
  logic        sel_we;
  logic [2:0]  sel_op;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        cmd_err;

  // Round-robin pick: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
      grant_port = ~last_q;
    end else begin
      grant_port = m1_req;
    end
  end

  // Mux the winning port's command
  always_comb begin
    if (grant_port) begin
      sel_we    = m1_we;
      sel_op    = m1_op;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else begin
      sel_we    = m0_we;
      sel_op    = m0_op;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
  end

  // Legality check of the winning command
  always_comb begin
    cmd_err = 1'b0;
    if (sel_addr >= ADDR_LIMIT) begin
      cmd_err = 1'b1;
    end
    case (sel_op)
      OpWord: begin
        if (sel_addr[1:0] != 2'b00) cmd_err = 1'b1;
      end
      OpLb, OpLboez: begin
        if (sel_we) cmd_err = 1'b1;
      end
      OpLh: begin
        if (sel_addr[0] || sel_we) cmd_err = 1'b1;
      end
      OpSb: begin
        if (!sel_we) cmd_err = 1'b1;
      end
      OpSh: begin
        if (sel_addr[0] || !sel_we) cmd_err = 1'b1;
      end
      default: cmd_err = 1'b1;
    endcase
  end

  // Next-state and latch control
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    last_d  = last_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          we_d    = sel_we;
          op_d    = sel_op;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          owner_d = grant_port;
          last_d  = grant_port;
          err_d   = cmd_err;
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Only a clean load returns memory data; stores and errors return 0
        rdata_d = (!we_q && !err_q) ? dm_rdata : 32'h0;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and command registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
    end
  end

  // Memory-side and requester-side outputs decoded from the current state
  always_comb begin
    dm_op    = op_q;
    dm_addr  = addr_q;
    dm_wdata = wdata_q;
    // Reset clears state_q asynchronously, so an aborted store never commits
    dm_we    = (state_q == StAccess) && we_q && !err_q;
    busy     = (state_q != StIdle);

    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = 32'h0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = 32'h0;

    if (state_q == StDone) begin
      if (owner_q) begin
        m1_ack   = 1'b1;
        m1_err   = err_q;
        m1_rdata = rdata_q;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = err_q;
        m0_rdata = rdata_q;
      end
    end
  end

endmodule
